// File: rtl/pipe_pkg.sv
// pipe_pkg
// Shared constants for the multi-cycle data-memory responder:
//   - FSM state encodings (IDLE / WAIT / ACCESS)
//   - width of the wait-state counter
//   - default address width (log2 of word count)
package pipe_pkg;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_WAIT   = 2'b01;
  localparam logic [1:0] ST_ACCESS = 2'b10;

  // Wide enough for WAIT_CYCLES in 0..15.
  localparam int CNT_W = 4;

  // 1024 x 32-bit words.
  localparam int DEF_AW = 10;

endpackage

// File: rtl/dmem_array.sv
// dmem_array
// Single-port word RAM with synchronous write and registered read.
// Contents are not reset.
// Ports:
//   clk   in   clock
//   we    in   write enable for the word at idx
//   idx   in   word index [AW-1:0]
//   din   in   write data [31:0]
//   dout  out  registered read data [31:0] (old contents on a write cycle)
module dmem_array #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   din,
  output logic [31:0]   dout
);

  logic [31:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= din;
    end
    dout <= mem[idx];
  end

endmodule

// File: rtl/pipe_dmem_resp.sv
// pipe_dmem_resp
// Data-memory responder for the MEM stage. Accepts one load/store over a
// req/ack handshake, waits WAIT_CYCLES, performs the access in a single
// ACCESS cycle and pulses ack in the following cycle.
// Ports:
//   clk    in   clock
//   clr    in   asynchronous active-high reset
//   req    in   access request, sampled only while idle
//   we     in   1 = store, 0 = load
//   addr   in   byte address; word index is addr[AW+1:2]
//   wdata  in   store data
//   ack    out  one-cycle completion pulse
//   rdata  out  registered load data, held until the next load completes
//   err    out  high with ack when the access was out of range
//   busy   out  high while a request is in flight
module pipe_dmem_resp
  import pipe_pkg::*;
#(
  parameter int AW          = DEF_AW,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy
);

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             we_q;
  logic [29:0]      word_q;
  logic [31:0]      wdata_q;

  logic             out_of_range;
  logic [AW-1:0]    ram_idx;
  logic             ram_we;
  logic [31:0]      ram_dout;
  logic             unused_byte_lane;

  // Byte-lane bits never select anything in a word memory.
  assign unused_byte_lane = ^addr[1:0];

  assign busy = (state != ST_IDLE);

  // Any word-address bit above the array index makes the access illegal.
  assign out_of_range = |(word_q >> AW);

  // The RAM read is registered, so while idle it is steered by the live
  // address: with zero wait states the accepted word is then already on
  // ram_dout in the ACCESS cycle. Once accepted, the latched address wins.
  assign ram_idx = (state == ST_IDLE) ? addr[AW+1:2] : word_q[AW-1:0];
  assign ram_we  = (state == ST_ACCESS) && we_q && !out_of_range;

  dmem_array #(.AW(AW)) u_array (
    .clk  (clk),
    .we   (ram_we),
    .idx  (ram_idx),
    .din  (wdata_q),
    .dout (ram_dout)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      ack     <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
      we_q    <= 1'b0;
      word_q  <= '0;
      wdata_q <= '0;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            we_q    <= we;
            word_q  <= addr[31:2];
            wdata_q <= wdata;
            cnt     <= WAIT_INIT;
            state   <= (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
          end
        end
        ST_WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // The store itself happens in the array via ram_we.
          ack   <= 1'b1;
          err   <= out_of_range;
          state <= ST_IDLE;
          if (!we_q) begin
            rdata <= out_of_range ? 32'd0 : ram_dout;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_dmem_resp.sv
// tb_pipe_dmem_resp
// Two responders share clock and reset: unit 0 with two wait states and
// unit 1 with none. Each request pushes its expected completion (ack cycle,
// err, rdata) computed from a word-array model; a monitor pops and compares
// on every ack.
module tb_pipe_dmem_resp;

  logic        clk = 1'b0;
  logic        clr;
  logic [1:0]  req, we, ack, err, busy;
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int          unit;
    int          ack_cyc;
    logic        err;
    logic [31:0] rdata;
    bit          chk;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] mem_m   [2][1024];
  bit          known_m [2][1024];
  logic [31:0] rd_m    [2];
  bit          rd_known[2];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  pipe_dmem_resp #(.AW(10), .WAIT_CYCLES(2)) dut0 (
    .clk(clk), .clr(clr), .req(req[0]), .we(we[0]), .addr(addr[0]),
    .wdata(wdata[0]), .ack(ack[0]), .rdata(rdata[0]), .err(err[0]),
    .busy(busy[0])
  );

  pipe_dmem_resp #(.AW(10), .WAIT_CYCLES(0)) dut1 (
    .clk(clk), .clr(clr), .req(req[1]), .we(we[1]), .addr(addr[1]),
    .wdata(wdata[1]), .ack(ack[1]), .rdata(rdata[1]), .err(err[1]),
    .busy(busy[1])
  );

  function automatic int wait_of(input int u);
    return (u == 0) ? 2 : 0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %h, want %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic checkReset(input string tag);
    for (int u = 0; u < 2; u++) begin
      checkOutput($sformatf("%s_ack_u%0d", tag, u),   {31'b0, ack[u]},  32'd0);
      checkOutput($sformatf("%s_err_u%0d", tag, u),   {31'b0, err[u]},  32'd0);
      checkOutput($sformatf("%s_busy_u%0d", tag, u),  {31'b0, busy[u]}, 32'd0);
      checkOutput($sformatf("%s_rdata_u%0d", tag, u), rdata[u],         32'd0);
    end
  endtask

  function automatic void model_reset();
    for (int u = 0; u < 2; u++) begin
      rd_m[u]     = 32'd0;
      rd_known[u] = 1'b1;
    end
  endfunction

  // Reference: a word array per unit; out-of-range means addr[31:12] != 0.
  function automatic void push_exp(input int u, input logic w,
                                   input logic [31:0] a, input logic [31:0] d,
                                   input int acc);
    exp_t e;
    bit   oor;
    int   idx;
    oor = (a[31:12] != 20'd0);
    idx = int'(a[11:2]);
    if (w) begin
      if (!oor) begin
        mem_m[u][idx]   = d;
        known_m[u][idx] = 1'b1;
      end
    end else if (oor) begin
      rd_m[u]     = 32'd0;
      rd_known[u] = 1'b1;
    end else begin
      rd_m[u]     = mem_m[u][idx];
      rd_known[u] = known_m[u][idx];
    end
    e.unit    = u;
    e.ack_cyc = acc + wait_of(u) + 2;
    e.err     = oor;
    e.rdata   = rd_m[u];
    e.chk     = rd_known[u];
    exp_q.push_back(e);
  endfunction

  // Monitor: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!clr) begin
      for (int u = 0; u < 2; u++) begin
        if (ack[u]) begin
          if (exp_q.size() == 0 || exp_q[0].unit != u) begin
            total++;
            bad++;
            $display("[TB] FAIL stray_ack_u%0d: got ack=1 at cycle %0d, want no ack", u, cyc);
          end else begin
            mon_e = exp_q.pop_front();
            checkOutput($sformatf("ack_cycle_u%0d", u), 32'(cyc), 32'(mon_e.ack_cyc));
            checkOutput($sformatf("err_u%0d", u), {31'b0, err[u]}, {31'b0, mon_e.err});
            if (mon_e.chk)
              checkOutput($sformatf("rdata_u%0d", u), rdata[u], mon_e.rdata);
          end
        end else if (err[u]) begin
          total++;
          bad++;
          $display("[TB] FAIL stray_err_u%0d: got err=1 without ack at cycle %0d, want 0", u, cyc);
        end
      end
    end
  end

  task automatic waitAck(input int u, output bit got, output int busy_cnt,
                         output logic busy_at_ack);
    got         = 1'b0;
    busy_cnt    = 0;
    busy_at_ack = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (ack[u]) begin
        got         = 1'b1;
        busy_at_ack = busy[u];
      end else if (busy[u]) begin
        busy_cnt++;
      end
    end
    if (!got) begin
      total++;
      bad++;
      $display("[TB] FAIL ack_timeout_u%0d: got no ack within 40 cycles, want ack", u);
    end
  endtask

  // One transaction; req drops and the request fields are scrambled one
  // cycle after accept, which the responder must ignore.
  task automatic applyStimulus(input int u, input logic w,
                               input logic [31:0] a, input logic [31:0] d);
    bit   got;
    int   bc;
    logic bat;
    @(posedge clk); #1;
    req[u] = 1'b1; we[u] = w; addr[u] = a; wdata[u] = d;
    push_exp(u, w, a, d, cyc);
    @(posedge clk); #1;
    req[u] = 1'b0; we[u] = ~w; addr[u] = $urandom; wdata[u] = $urandom;
    waitAck(u, got, bc, bat);
    if (got) begin
      checkOutput($sformatf("busy_cycles_u%0d", u), 32'(bc), 32'(wait_of(u) + 1));
      checkOutput($sformatf("busy_at_ack_u%0d", u), {31'b0, bat}, 32'd0);
    end
  endtask

  // req stays high through the first ack carrying the second request.
  task automatic applyBackToBack(input int u,
                                 input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                                 input logic w2, input logic [31:0] a2, input logic [31:0] d2);
    bit   got;
    int   bc;
    logic bat;
    int   n;
    @(posedge clk); #1;
    req[u] = 1'b1; we[u] = w1; addr[u] = a1; wdata[u] = d1;
    n = cyc;
    push_exp(u, w1, a1, d1, n);
    @(posedge clk); #1;
    we[u] = w2; addr[u] = a2; wdata[u] = d2;
    while (cyc < n + wait_of(u) + 2) begin
      @(posedge clk); #1;
    end
    push_exp(u, w2, a2, d2, cyc);
    @(posedge clk); #1;
    req[u] = 1'b0;
    waitAck(u, got, bc, bat);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    logic [9:0]  idx;
    idx = ($urandom_range(0, 9) == 0) ? 10'd1023 : 10'($urandom_range(0, 15));
    a = {20'd0, idx, 2'($urandom_range(0, 3))};
    if ($urandom_range(0, 9) == 0)
      a[31:12] = 20'($urandom_range(1, 20'hFFFFF));
    return a;
  endfunction

  initial begin
    int u;
    clr = 1'b1;
    req = 2'b00;
    we  = 2'b00;
    for (int i = 0; i < 2; i++) begin
      addr[i]  = 32'd0;
      wdata[i] = 32'd0;
    end
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkReset("reset");
    @(posedge clk); #1;
    clr = 1'b0;

    // Store then load with two wait states.
    applyStimulus(0, 1'b1, 32'h10, 32'hDEADBEEF);
    applyStimulus(0, 1'b0, 32'h10, 32'h0);

    // Zero wait states.
    applyStimulus(1, 1'b1, 32'h4, 32'h12345678);
    applyStimulus(1, 1'b0, 32'h4, 32'h0);

    // Out-of-range store aliases word 0 in the low bits; it must be dropped.
    applyStimulus(0, 1'b1, 32'h0, 32'h0BADF00D);
    applyStimulus(0, 1'b1, 32'h0001_0000, 32'hFFFFFFFF);
    applyStimulus(0, 1'b0, 32'h0001_0000, 32'h0);
    applyStimulus(0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1, 1'b1, 32'h8000_0000, 32'h1);

    // Reset during WAIT aborts a store.
    applyStimulus(0, 1'b1, 32'h20, 32'h11112222);
    @(posedge clk); #1;
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'hAAAA5555;
    @(posedge clk); #1;
    req[0] = 1'b0;
    #2 clr = 1'b1;
    #1 checkReset("abort");
    model_reset();
    @(posedge clk); #1;
    clr = 1'b0;
    applyStimulus(0, 1'b0, 32'h20, 32'h0);

    // Back-to-back requests, including read-after-write.
    applyBackToBack(0, 1'b0, 32'h10, 32'h0, 1'b1, 32'h30, 32'hCAFEF00D);
    applyStimulus(0, 1'b0, 32'h30, 32'h0);
    applyBackToBack(1, 1'b1, 32'h8, 32'h55AA55AA, 1'b0, 32'h8, 32'h0);
    applyBackToBack(0, 1'b1, 32'h3C, 32'h01020304, 1'b0, 32'h3C, 32'h0);

    // Random traffic on both units.
    for (int i = 0; i < 120; i++) begin
      u = int'($urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      if ($urandom_range(0, 5) == 0)
        applyBackToBack(u, 1'($urandom), rand_addr(), $urandom,
                        1'($urandom), rand_addr(), $urandom);
      else
        applyStimulus(u, 1'($urandom), rand_addr(), $urandom);
    end

    repeat (5) @(posedge clk);
    checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_dmem_resp.md
Name: pipe_dmem_resp

Overview:
- Data-memory responder serving the MEM stage's load/store requests over a req/ack handshake.
- Models a multi-cycle memory with programmable wait states; the pipeline stalls while a request is outstanding (`stall = req & ~ack`, generated outside this block).
- Replaces the single-cycle data RAM when memory latency is greater than zero.

Parameters:
- AW, 10, log2 of word count (1024 x 32-bit words).
- WAIT_CYCLES, 2, wait states inserted between request accept and access (0..15).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- clr  in  1  reset, asynchronous, active-high.
- req  in  1  access request from MEM stage; held high until ack.
- we  in  1  1 = store, 0 = load; valid with req.
- addr  in  32  byte address; word index is addr[AW+1:2], addr[1:0] ignored.
- wdata  in  32  store data; valid with req.
- ack  out  1  one-cycle completion pulse.
- rdata  out  32  load data; registered.
- err  out  1  registered; 1 for the ack cycle of an out-of-range access.
- busy  out  1  high while state != IDLE.

Behaviour:
- Reset values: ack=0, rdata=0, err=0, busy=0, state=IDLE, wait counter=0. Array contents are not reset.
- State machine IDLE / WAIT / ACCESS.
- IDLE:
  - req sampled only in IDLE.
  - On req=1: latch we, addr, wdata; load counter with WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES>0, else ACCESS.
- WAIT: counter decrements each cycle; when counter==1 the next state is ACCESS.
- ACCESS (exactly one cycle):
  - In range: store writes the latched wdata to the array; load loads rdata with the array word.
  - ack=1 in the cycle after ACCESS (registered); state returns to IDLE in that same cycle.
- Latency: req first high in cycle N -> ack high in cycle N+WAIT_CYCLES+2; rdata valid in the ack cycle.
- rdata holds its value until the next load completes. Stores and error loads other than the one below leave rdata unchanged.
- Out of range = any of addr[31:AW+2] nonzero:
  - store is dropped with no array change;
  - load returns rdata=0;
  - err=1 in the ack cycle.
- err and ack are 0 in every other cycle.
- Request inputs are latched at accept, so changes to req/we/addr/wdata after accept are ignored. If req drops before ack, the transaction still completes.
- Back-to-back: req high in the ack cycle is seen in IDLE and accepted as a new request. The initiator must drop req in the ack cycle unless it intends a new access.
- Reset mid-operation: immediate return to IDLE, outputs cleared. A store aborted before ACCESS never writes. A store in ACCESS when clr rises is not guaranteed.
- Read-after-write to the same word in consecutive transactions returns the new data, since the array write completes in ACCESS before the next accept.

Decomposition:
- Shared package (pipe_pkg): state encodings (IDLE=2'b00, WAIT=2'b01, ACCESS=2'b10), WAIT counter width constant (4), default AW.
- One sub-module, dmem_array: synchronous-write, registered-read single-port word RAM with parameter AW. Ports: clk, we, idx[AW-1:0], din[31:0], dout[31:0]. It is instantiated once; the FSM, latches and range check stay in pipe_dmem_resp.

Test Plan:
- Default params, store 0xDEADBEEF to addr 0x10, then load addr 0x10 -> store ack at N+4; load ack at M+4 with rdata=0xDEADBEEF, err=0.
- WAIT_CYCLES=0, load addr 0x4 after storing 0x12345678 -> ack at N+2, rdata=0x12345678, busy high for exactly 1 cycle before ack.
- Store to addr 0x0001_0000 (out of range, AW=10), then load addr 0x0001_0000 -> both acks have err=1; load rdata=0; no in-range word modified (check addr 0x0 is unchanged).
- Accept a store to 0x20 of 0xAAAA5555, assert clr for 1 cycle during WAIT, then load 0x20 -> ack/busy cleared immediately; loaded value equals the pre-store content (store aborted).
- Drop req and change addr one cycle after accept -> transaction completes at the originally latched address with ack at N+4.
- Hold req high through the ack cycle with a new addr -> second transaction accepted in the cycle after the first ack; two separate ack pulses, 4 cycles apart.
